// File: rtl/mem_port_ram.sv
// rtl/mem_port_ram.sv - multi-port byte-addressed RAM with registered write-first reads
module mem_port_ram #(
    parameter int NR             = 3,
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int DEPTH_BYTES    = 65536,
    parameter int RD_LATENCY     = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NR-1:0]                rd_en,
    input  logic [NR*AXI_ADDR_WIDTH-1:0] rd_addr,
    output logic [NR*AXI_WIDTH-1:0]      rd_data,
    output logic [NR-1:0]                rd_valid,
    output logic [NR-1:0]                rd_err,
    input  logic                         wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0]    wr_addr,
    input  logic [AXI_WIDTH-1:0]         wr_data,
    input  logic [AXI_WIDTH/8-1:0]       wr_strb,
    output logic                         wr_err,
    output logic [15:0]                  err_count
);
    localparam int NB = AXI_WIDTH / 8;
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int EW = AW + 1;
    localparam int IW = $clog2(DEPTH_BYTES);
    localparam logic [EW-1:0] LO = {1'b0, BASE_ADDR};
    localparam logic [EW-1:0] HI = LO + EW'(DEPTH_BYTES);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "mem_port_ram: RD_LATENCY must be 1..4");
    end
    if (AXI_WIDTH % 8 != 0) begin : g_bad_width
        $fatal(1, "mem_port_ram: AXI_WIDTH must be a multiple of 8");
    end

    // Byte addresses carry one extra bit so addr+i never wraps into range.
    function automatic logic in_range(input logic [EW-1:0] a);
        return (a >= LO) && (a < HI);
    endfunction

    logic [7:0]              mem [DEPTH_BYTES];
    logic [NB-1:0]           wr_ok;
    logic [IW-1:0]           wr_idx [NB];
    logic                    wr_oor;
    logic [NR*AXI_WIDTH-1:0] req_data;
    logic [NR-1:0]           req_err;

    always_comb begin
        logic [EW-1:0] wa;
        wa     = '0;
        wr_oor = 1'b0;
        for (int i = 0; i < NB; i++) begin
            wa        = {1'b0, wr_addr} + EW'(i);
            wr_idx[i] = IW'(wa - LO);
            wr_ok[i]  = wr_strb[i] && in_range(wa);
            wr_oor    = wr_oor || (wr_strb[i] && !in_range(wa));
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_ok[i]) mem[wr_idx[i]] <= wr_data[8*i +: 8];
            end
        end
    end

    // Same-edge write bytes override the array so the read sees the new data.
    always_comb begin
        logic [EW-1:0] ra;
        logic [EW-1:0] diff;
        int            j;
        req_data = '0;
        req_err  = '0;
        ra       = '0;
        diff     = '0;
        j        = 0;
        for (int p = 0; p < NR; p++) begin
            for (int i = 0; i < NB; i++) begin
                ra   = {1'b0, rd_addr[p*AW +: AW]} + EW'(i);
                diff = ra - {1'b0, wr_addr};
                if (!in_range(ra)) begin
                    req_err[p] = 1'b1;
                end else begin
                    req_data[(p*NB+i)*8 +: 8] = mem[IW'(ra - LO)];
                    if (wr_en && (ra >= {1'b0, wr_addr}) && (diff < EW'(NB))) begin
                        j = int'(diff);
                        if (wr_strb[j]) req_data[(p*NB+i)*8 +: 8] = wr_data[8*j +: 8];
                    end
                end
            end
        end
    end

    logic [NR-1:0]           vld_q [RD_LATENCY];
    logic [NR-1:0]           vld_d [RD_LATENCY];
    logic [NR-1:0]           err_q [RD_LATENCY];
    logic [NR-1:0]           err_d [RD_LATENCY];
    logic [NR*AXI_WIDTH-1:0] dat_q [RD_LATENCY];
    logic [NR*AXI_WIDTH-1:0] dat_d [RD_LATENCY];
    logic [NR-1:0]           v_in  [RD_LATENCY];
    logic [NR-1:0]           e_in  [RD_LATENCY];
    logic [NR*AXI_WIDTH-1:0] d_in  [RD_LATENCY];
    logic                    wr_err_q, wr_err_d;
    logic [15:0]             cnt_q, cnt_d;

    // Data/err only load with a valid beat, so the output holds between beats.
    always_comb begin
        v_in[0] = rd_en;
        e_in[0] = req_err;
        d_in[0] = req_data;
        for (int s = 1; s < RD_LATENCY; s++) begin
            v_in[s] = vld_q[s-1];
            e_in[s] = err_q[s-1];
            d_in[s] = dat_q[s-1];
        end
        for (int s = 0; s < RD_LATENCY; s++) begin
            vld_d[s] = v_in[s];
            err_d[s] = err_q[s];
            dat_d[s] = dat_q[s];
            for (int p = 0; p < NR; p++) begin
                if (v_in[s][p]) begin
                    err_d[s][p]                         = e_in[s][p];
                    dat_d[s][p*AXI_WIDTH +: AXI_WIDTH] = d_in[s][p*AXI_WIDTH +: AXI_WIDTH];
                end
            end
        end
    end

    always_comb begin
        logic [16:0] sum;
        sum      = {1'b0, cnt_q} + 17'($countones(rd_valid & rd_err)) + 17'(wr_err_q);
        cnt_d    = sum[16] ? 16'hFFFF : sum[15:0];
        wr_err_d = wr_en && wr_oor;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                vld_q[s] <= '0;
                err_q[s] <= '0;
                dat_q[s] <= '0;
            end
            wr_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                vld_q[s] <= vld_d[s];
                err_q[s] <= err_d[s];
                dat_q[s] <= dat_d[s];
            end
            wr_err_q <= wr_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_valid  = vld_q[RD_LATENCY-1];
    assign rd_err    = err_q[RD_LATENCY-1] & vld_q[RD_LATENCY-1];
    assign rd_data   = dat_q[RD_LATENCY-1];
    assign wr_err    = wr_err_q;
    assign err_count = cnt_q;
endmodule

// File: tb/tb_mem_port_ram.sv
// tb/tb_mem_port_ram.sv - self-checking bench for mem_port_ram at read latencies 1 and 3
module tb_mem_port_ram;
    localparam int NR = 3;
    localparam int W  = 128;
    localparam int AW = 32;
    localparam int NB = 16;
    localparam longint BASE  = 0;
    localparam longint DEPTH = 65536;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic [NB-1:0]     wr_strb;

    logic [NR-1:0]     o_v   [2];
    logic [NR*W-1:0]   o_d   [2];
    logic [NR-1:0]     o_e   [2];
    logic              o_we  [2];
    logic [15:0]       o_cnt [2];

    always #5 clk = ~clk;

    mem_port_ram #(.NR(NR), .AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .BASE_ADDR(32'h0),
                   .DEPTH_BYTES(65536), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(o_d[0]),
        .rd_valid(o_v[0]), .rd_err(o_e[0]), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(o_we[0]), .err_count(o_cnt[0]));

    mem_port_ram #(.NR(NR), .AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .BASE_ADDR(32'h0),
                   .DEPTH_BYTES(65536), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(o_d[1]),
        .rd_valid(o_v[1]), .rd_err(o_e[1]), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(o_we[1]), .err_count(o_cnt[1]));

    // Reference: flat byte array, writes applied before same-edge reads.
    logic [7:0]    mm [65536];
    logic [NR-1:0] h_v [8];
    logic [NR-1:0] h_e [8];
    logic [W-1:0]  h_d [8][NR];
    logic [NR-1:0] ev [2];
    logic [NR-1:0] ee [2];
    logic [W-1:0]  ed [2][NR];
    logic          exp_we;
    int            cnt [2];
    int            pend [2];
    int            cyc = 0;
    int            rst_cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit in_rng(input longint a);
        return (a >= BASE) && (a < BASE + DEPTH);
    endfunction

    task automatic chk(input string tag, input int k, input int p, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s inst%0d port%0d: observed %h expected %h", tag, k, p, obs, exp);
            $error("%s inst%0d port%0d observed %h expected %h", tag, k, p, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; pend[k] = 0; ev[k] = '0; ee[k] = '0;
            for (int p = 0; p < NR; p++) ed[k][p] = '0;
        end
        exp_we  = 1'b0;
        rst_cyc = cyc;
    endtask

    task automatic model_edge();
        bit            werr;
        longint        a;
        int            s;
        logic [NR-1:0] v, e;
        logic [W-1:0]  d [NR];
        cyc++;
        if (!rstn) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) cnt[k] = (cnt[k] + pend[k] > 65535) ? 65535 : cnt[k] + pend[k];
        werr = 1'b0;
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_strb[i]) begin
                    a = longint'(wr_addr) + i;
                    if (in_rng(a)) mm[a - BASE] = wr_data[8*i +: 8];
                    else werr = 1'b1;
                end
            end
        end
        for (int p = 0; p < NR; p++) begin
            v[p] = rd_en[p]; e[p] = 1'b0; d[p] = '0;
            if (v[p]) begin
                for (int i = 0; i < NB; i++) begin
                    a = longint'(rd_addr[p*AW +: AW]) + i;
                    if (in_rng(a)) d[p][8*i +: 8] = mm[a - BASE];
                    else e[p] = 1'b1;
                end
            end
        end
        h_v[cyc % 8] = v; h_e[cyc % 8] = e; h_d[cyc % 8] = d;
        exp_we = werr;
        for (int k = 0; k < 2; k++) begin
            s = cyc - lat_of(k) + 1;
            ev[k] = '0; ee[k] = '0;
            if (s > rst_cyc) begin
                ev[k] = h_v[s % 8];
                ee[k] = h_e[s % 8] & h_v[s % 8];
                for (int p = 0; p < NR; p++) if (ev[k][p]) ed[k][p] = h_d[s % 8][p];
            end
            pend[k] = $countones(ev[k] & ee[k]) + int'(werr);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk("rd_valid", k, 0, W'(o_v[k]), W'(ev[k]));
            chk("wr_err", k, 0, W'(o_we[k]), W'(exp_we));
            chk("err_count", k, 0, W'(o_cnt[k]), W'(cnt[k]));
            for (int p = 0; p < NR; p++) begin
                chk("rd_data", k, p, o_d[k][p*W +: W], ed[k][p]);
                if (ev[k][p]) chk("rd_err", k, p, W'(o_e[k][p]), W'(ee[k][p]));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle();
        rd_en = '0; wr_en = 1'b0; wr_strb = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return 32'(DEPTH) - 32'($urandom_range(1, 16));
            1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2:       return 32'($urandom);
            3:       return 32'($urandom_range(0, 63));
            default: return 32'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        rstn = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        idle();
        model_reset();
        repeat (3) cycle();
        rstn = 1'b1;

        for (int a = 0; a < 65536; a += NB) begin
            set_wr(32'(a), rnd_data(), 16'hFFFF);
            cycle();
        end
        idle();

        // 1: aligned write then read one cycle later
        set_wr(32'h10, 128'h0f0e0d0c0b0a09080706050403020100, 16'hFFFF);
        cycle();
        idle();
        set_rd(0, 32'h10);
        cycle();
        idle();
        chk("t1_valid", 0, 0, W'(o_v[0][0]), W'(1'b1));
        chk("t1_data", 0, 0, o_d[0][W-1:0], 128'h0f0e0d0c0b0a09080706050403020100);
        repeat (3) cycle();

        // 2: unaligned read, latency-3 timing
        set_rd(0, 32'h13);
        cycle();
        idle();
        cycle();
        chk("t2_not_yet", 1, 0, W'(o_v[1][0]), W'(1'b0));
        cycle();
        chk("t2_valid", 1, 0, W'(o_v[1][0]), W'(1'b1));
        chk("t2_data", 1, 0, W'(o_d[1][103:0]), W'(104'h0f0e0d0c0b0a09080706050403));
        repeat (2) cycle();

        // 3: same-edge write and read on all ports
        set_wr(32'h10, {16{8'hAA}}, 16'h00FF);
        for (int p = 0; p < NR; p++) set_rd(p, 32'h10);
        cycle();
        idle();
        for (int p = 0; p < NR; p++)
            chk("t3_bypass", 0, p, o_d[0][p*W +: W], 128'h0f0e0d0c0b0a0908aaaaaaaaaaaaaaaa);
        repeat (3) cycle();

        // 4: read and write straddling the top of the RAM
        set_rd(0, 32'(DEPTH - 4));
        cycle();
        idle();
        chk("t4_rd_err", 0, 0, W'(o_e[0][0]), W'(1'b1));
        cycle();
        chk("t4_cnt1", 0, 0, W'(o_cnt[0]), W'(16'd1));
        repeat (3) cycle();
        set_wr(32'(DEPTH - 4), rnd_data(), 16'hFFFF);
        cycle();
        idle();
        chk("t4_wr_err", 0, 0, W'(o_we[0]), W'(1'b1));
        cycle();
        chk("t4_cnt2", 0, 0, W'(o_cnt[0]), W'(16'd2));
        set_rd(0, 32'(DEPTH - 4));
        set_rd(1, 32'h0);
        cycle();
        idle();
        repeat (3) cycle();

        // 5: back-to-back reads, then reset with reads in flight
        for (int c = 0; c < 10; c++) begin
            for (int p = 0; p < NR; p++) set_rd(p, 32'($urandom_range(0, 65535)));
            cycle();
        end
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        set_wr(32'h10, {16{8'h55}}, 16'hFFFF);
        repeat (2) cycle();
        idle();
        rstn = 1'b1;
        repeat (4) cycle();
        for (int p = 0; p < NR; p++) set_rd(p, 32'(32'h10 + p));
        cycle();
        idle();
        repeat (3) cycle();

        // random mix of reads, writes, collisions and out-of-range accesses
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int p = 0; p < NR; p++) if ($urandom_range(0, 3) != 0) set_rd(p, rnd_addr());
            if ($urandom_range(0, 1) == 1) begin
                set_wr(($urandom_range(0, 2) == 0) ? rd_addr[AW-1:0] : rnd_addr(), rnd_data(), NB'($urandom));
            end
            cycle();
        end
        idle();
        repeat (4) cycle();

        // 6: saturate the error counter
        for (int p = 0; p < NR; p++) set_rd(p, 32'h0002_0000);
        for (int c = 0; c < 23400; c++) cycle();
        idle();
        repeat (4) cycle();
        chk("t6_sat", 0, 0, W'(o_cnt[0]), W'(16'hFFFF));
        chk("t6_sat", 1, 0, W'(o_cnt[1]), W'(16'hFFFF));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
